program_loader: RTL and testbench

- Writer side of the instruction-memory interface. The processor only reads instruction memory; this block fills it.
- Receives a byte stream over a valid/ready handshake, frames it into 32-bit MIPS instruction words, and writes them sequentially into program memory.
- Holds the processor in reset until a complete, checksum-verified image is loaded.
- Sits between the host byte link (e.g. a UART receiver) and the program-memory write port, beside the processor top level.

---
 rtl/program_loader.sv | 120 ++++++++++++
 tb/tb_program_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program image loader for instruction memory
module program_loader #(
   parameter int          MEMORY_DEPTH = 64,
   parameter int          ADDR_WIDTH   = 6,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            byte_data_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_address_o,
   output logic [31:0]           mem_data_o,
   output logic                  cpu_reset_o,
   output logic                  done_o,
   output logic                  error_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   state_t                state_next;
   logic                  accept;
   logic [7:0]            count_lo;
   logic [15:0]           frame_count;
   logic [15:0]           words_left;
   logic [1:0]            byte_idx;
   logic [23:0]           word_acc;
   logic [7:0]            checksum;
   logic [ADDR_WIDTH-1:0] write_addr;

   assign accept      = byte_valid_i && byte_ready_o;
   assign frame_count = {byte_data_i, count_lo};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Frame parser: advances only on accepted bytes, so idle gaps simply hold.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (accept && byte_data_i == SYNC_BYTE) state_next = S_CNT_LO;
         S_CNT_LO: if (accept) state_next = S_CNT_HI;
         S_CNT_HI: begin
            if (accept) begin
               if (frame_count > 16'(MEMORY_DEPTH)) state_next = S_ERROR;
               else if (frame_count == 16'd0)       state_next = S_CHECK;
               else                                 state_next = S_DATA;
            end
         end
         S_DATA:   if (accept && byte_idx == 2'd3 && words_left == 16'd1) state_next = S_CHECK;
         S_CHECK:  if (accept) state_next = (byte_data_i == checksum) ? S_DONE : S_ERROR;
         S_DONE:   state_next = S_DONE;
         S_ERROR:  state_next = S_ERROR;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; status flags follow the next state so
   // they rise on the same edge that accepts the deciding byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_ready_o  <= 1'b1;
         mem_write_o   <= 1'b0;
         mem_address_o <= '0;
         mem_data_o    <= '0;
         cpu_reset_o   <= 1'b1;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
         count_lo      <= '0;
         words_left    <= '0;
         byte_idx      <= '0;
         word_acc      <= '0;
         checksum      <= '0;
         write_addr    <= '0;
      end else begin
         mem_write_o  <= 1'b0;
         byte_ready_o <= !(state_next == S_DONE || state_next == S_ERROR);
         cpu_reset_o  <= (state_next != S_DONE);
         done_o       <= (state_next == S_DONE);
         error_o      <= (state_next == S_ERROR);
         if (accept) begin
            case (state)
               S_CNT_LO: count_lo <= byte_data_i;
               S_CNT_HI: begin
                  words_left <= frame_count;
                  byte_idx   <= '0;
                  checksum   <= '0;
               end
               S_DATA: begin
                  checksum <= checksum ^ byte_data_i;
                  byte_idx <= byte_idx + 2'd1;
                  word_acc <= {word_acc[15:0], byte_data_i};
                  if (byte_idx == 2'd3) begin
                     mem_write_o   <= 1'b1;
                     mem_data_o    <= {word_acc, byte_data_i};
                     mem_address_o <= write_addr;
                     write_addr    <= write_addr + ADDR_WIDTH'(1);
                     words_left    <= words_left - 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  byte_data_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic        mem_write_o;
   logic [5:0]  mem_address_o;
   logic [31:0] mem_data_o;
   logic        cpu_reset_o;
   logic        done_o;
   logic        error_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  frame[$];
   logic [5:0]  got_addr[$];
   logic [31:0] got_data[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_done;
   logic        exp_err;

   program_loader #(.MEMORY_DEPTH(64), .ADDR_WIDTH(6), .SYNC_BYTE(8'hA5)) dut (
      .clk           (clk),
      .reset         (reset),
      .byte_data_i   (byte_data_i),
      .byte_valid_i  (byte_valid_i),
      .byte_ready_o  (byte_ready_o),
      .mem_write_o   (mem_write_o),
      .mem_address_o (mem_address_o),
      .mem_data_o    (mem_data_o),
      .cpu_reset_o   (cpu_reset_o),
      .done_o        (done_o),
      .error_o       (error_o)
   );

   always #5 clk = ~clk;

   // Record every strobe cycle; a strobe held two cycles shows up as an extra entry.
   always @(negedge clk) begin
      if (mem_write_o) begin
         got_addr.push_back(mem_address_o);
         got_data.push_back(mem_data_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      got_addr.delete();
      got_data.delete();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   // Reference: locate the sync byte, read the count, slice the payload into
   // big-endian words and compare the trailing byte with the payload XOR.
   task automatic model();
      int          i;
      int          n;
      int          p;
      logic [7:0]  chk;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      i = 0;
      while (i < frame.size() && frame[i] != 8'hA5) i++;
      if (i + 2 >= frame.size()) return;
      n = int'(frame[i+1]) + 256 * int'(frame[i+2]);
      if (n > 64) begin
         exp_err = 1'b1;
         return;
      end
      p   = i + 3;
      chk = 8'h00;
      for (int w = 0; w < n; w++) begin
         exp_addr.push_back(w);
         exp_data.push_back({frame[p], frame[p+1], frame[p+2], frame[p+3]});
         for (int k = 0; k < 4; k++) chk = chk ^ frame[p+k];
         p += 4;
      end
      exp_done = (frame[p] == chk);
      exp_err  = !exp_done;
   endtask

   task automatic run_frame(input string tag, input bit gaps);
      model();
      foreach (frame[i]) send(frame[i], gaps ? int'($urandom_range(0, 5)) : 0);
      repeat (2) @(negedge clk);
      check({tag, ".nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check({tag, ".addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
         check({tag, ".data"}, got_data[i], exp_data[i]);
      end
      check({tag, ".done"},  32'(done_o),       32'(exp_done));
      check({tag, ".error"}, 32'(error_o),      32'(exp_err));
      check({tag, ".cpurst"}, 32'(cpu_reset_o), 32'(!exp_done));
      check({tag, ".ready"}, 32'(byte_ready_o), 32'(!(exp_done || exp_err)));
   endtask

   task automatic build(input int n, input bit bad, input int garbage);
      logic [7:0] b;
      logic [7:0] chk;
      frame.delete();
      for (int g = 0; g < garbage; g++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         frame.push_back(b);
      end
      frame.push_back(8'hA5);
      frame.push_back(8'(n));
      frame.push_back(8'(n >> 8));
      chk = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom_range(0, 255));
         frame.push_back(b);
         chk = chk ^ b;
      end
      if (bad) chk = chk ^ 8'($urandom_range(1, 255));
      frame.push_back(chk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".ready"},  32'(byte_ready_o),  32'd1);
      check({tag, ".write"},  32'(mem_write_o),   32'd0);
      check({tag, ".addr"},   32'(mem_address_o), 32'd0);
      check({tag, ".data"},   mem_data_o,         32'd0);
      check({tag, ".cpurst"}, 32'(cpu_reset_o),   32'd1);
      check({tag, ".done"},   32'(done_o),        32'd0);
      check({tag, ".error"},  32'(error_o),       32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'h00;

      do_reset();
      check_reset_outputs("rst");

      // Nominal image; payload XOR is 8'h03.
      frame = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
      run_frame("nominal", 1'b0);
      check("nominal.w0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h20080005);
      check("nominal.w1", (got_data.size() > 1) ? got_data[1] : 32'hx, 32'h20090007);
      send(8'hA5, 0);
      send(8'h01, 0);
      repeat (2) @(negedge clk);
      check("sticky_done.nwrites", 32'(got_addr.size()), 32'd2);
      check("sticky_done.done",    32'(done_o),          32'd1);

      // Bad checksum.
      do_reset();
      frame = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h07, 8'h23};
      run_frame("badchk", 1'b0);

      // Oversize count, then further input must not change anything.
      do_reset();
      frame = '{8'hA5, 8'h41, 8'h00};
      run_frame("oversize", 1'b0);
      send(8'h00, 0);
      send(8'h00, 0);
      repeat (2) @(negedge clk);
      check("sticky_err.error", 32'(error_o), 32'd1);
      check("sticky_err.nwrites", 32'(got_addr.size()), 32'd0);

      // Garbage before sync plus random gaps.
      do_reset();
      frame = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
      run_frame("gaps", 1'b1);

      // Empty image, good and bad checksum.
      do_reset();
      frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame("empty", 1'b0);
      do_reset();
      frame = '{8'hA5, 8'h00, 8'h00, 8'h01};
      run_frame("empty_bad", 1'b0);

      // Reset after the 2nd payload byte of word 0.
      do_reset();
      send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h20, 0); send(8'h08, 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      reset = 1'b0;
      got_addr.delete();
      got_data.delete();
      frame = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
      run_frame("after_midrst", 1'b0);

      // Reset after a word has been written: data and address must clear too.
      do_reset();
      send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
      send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0); send(8'h11, 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst2");
      reset = 1'b0;

      // Randomized frames, including a full-depth image and oversize counts.
      for (int t = 0; t < 8; t++) begin
         do_reset();
         if (t == 0)      build(64, 1'b0, 2);
         else if (t == 1) begin
            frame.delete();
            frame.push_back(8'hA5);
            frame.push_back(8'($urandom_range(65, 255)));
            frame.push_back(8'($urandom_range(0, 3)));
         end
         else             build(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)));
         run_frame($sformatf("rand%0d", t), t[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
